// File: rtl/mux41_rr_arbiter.sv
// Four-way round-robin arbiter with a registered grant/select and a data mux.
// Each grant is held until its requester drops, signals last, or reaches HOLD_MAX cycles.
module mux41_rr_arbiter #(
  parameter int unsigned DW       = 2,
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [3:0]      req,
  input  logic [3:0]      last,
  input  logic [4*DW-1:0] din,
  output logic [3:0]      gnt,
  output logic [1:0]      sel,
  output logic [DW-1:0]   dout,
  output logic            valid
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  localparam logic [3:0] HoldMax = 4'(HOLD_MAX);

  logic [0:0] state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;

  logic [1:0] win;
  logic       launch;
  logic       release_now;

  // Search starts just after the most recent winner, so that winner comes last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    win   = ptr_q;
    found = 1'b0;
    idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign launch      = en && (req != 4'b0000);
  assign release_now = !req[sel_q] || last[sel_q] || (cnt_q == HoldMax);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StGrant;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          ptr_d   = win;
          cnt_d   = 4'd1;
        end
      end
      StGrant: begin
        if (release_now) begin
          if (launch) begin
            gnt_d = 4'b0001 << win;
            sel_d = win;
            ptr_d = win;
            cnt_d = 4'd1;
          end else begin
            // sel keeps its last value while idle
            state_d = StIdle;
            gnt_d   = 4'b0000;
            cnt_d   = 4'd0;
          end
        end else if (cnt_q != HoldMax) begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;

  always_comb begin
    dout = '0;
    if (valid) dout = din[DW*int'(sel_q) +: DW];
  end

endmodule
